// File: rtl/classifier_feeder_pkg.sv
// classifier_feeder_pkg: shared constants and types for the classifier frame feeder.
// Contents: frame geometry, classifier RAM widths, bank-select type.
package classifier_feeder_pkg;

    localparam int unsigned PIXELS_PER_FRAME = 784;
    localparam int unsigned ADDR_W           = 10;
    localparam int unsigned PIXEL_W          = 8;
    localparam int unsigned DATA_W           = 16;
    localparam int unsigned LAST_PIXEL       = PIXELS_PER_FRAME - 1;

    typedef logic [0:0] bank_sel_t;

endpackage

// File: rtl/feeder_frame_bank.sv
// feeder_frame_bank: one 784x8 frame store, one write port and one registered read port.
// Ports:
//   clk, reset           clock, async active-high reset (read register only)
//   we, waddr, wdata     write port
//   raddr                read address; addresses past the last pixel read as 0
//   rdata                registered read data
module feeder_frame_bank
    import classifier_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [PIXEL_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [PIXEL_W-1:0] rdata
);

    logic [PIXEL_W-1:0] mem [PIXELS_PER_FRAME];

    // Storage is never reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with out-of-range addresses forced to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (raddr <= ADDR_W'(LAST_PIXEL)) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/classifier_frame_feeder.sv
// classifier_frame_feeder: ping-pong frame buffer between an upstream pixel stream and
// the classifier's input_valid flag register and input RAM read port.
// Ports:
//   clk, reset                               clock, async active-high reset
//   pixel_in_data/valid/ready                upstream valid/ready pixel stream
//   classifier_input_valid_write_en/data     accelerator writes 0 to release a frame
//   classifier_input_valid_read_data         {7'b0, frame_ready}
//   classifier_input_address_a               pixel address within the presented frame
//   classifier_input_read_data_a             {8'b0, pixel}, one-cycle latency
//   frames_released                          release counter, present only when
//                                            CLASSIFIER_FEEDER_FRAME_COUNT_EN is defined
module classifier_frame_feeder
    import classifier_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] pixel_in_data,
    input  logic               pixel_in_valid,
    output logic               pixel_in_ready,
    input  logic               classifier_input_valid_write_en,
    input  logic [7:0]         classifier_input_valid_write_data,
    output logic [7:0]         classifier_input_valid_read_data,
    input  logic [ADDR_W-1:0]  classifier_input_address_a,
    output logic [DATA_W-1:0]  classifier_input_read_data_a
`ifdef CLASSIFIER_FEEDER_FRAME_COUNT_EN
    ,
    output logic [15:0]        frames_released
`endif
);

    logic [1:0]         full;
    logic [1:0]         full_next;
    bank_sel_t          wr_bank;
    bank_sel_t          rd_bank;
    bank_sel_t          rd_bank_q;
    logic [ADDR_W-1:0]  wr_count;
    logic               frame_ready;
    logic               xfer;
    logic               fill_done;
    logic               release_frame;
    logic [PIXEL_W-1:0] bank_rdata [2];
    logic               unused_write_bits;

    assign unused_write_bits = ^classifier_input_valid_write_data[7:1];

    // Handshake and event decode.
    assign pixel_in_ready = ~reset & ~full[wr_bank];
    assign frame_ready    = full[rd_bank];
    assign xfer           = pixel_in_valid & pixel_in_ready;
    assign fill_done      = xfer & (wr_count == ADDR_W'(LAST_PIXEL));
    assign release_frame  = classifier_input_valid_write_en &
                            ~classifier_input_valid_write_data[0] & frame_ready;

    // Set and clear can only coincide on different banks: a fill needs its bank empty,
    // a release needs its bank full.
    always_comb begin
        full_next = full;
        if (fill_done) begin
            full_next[wr_bank] = 1'b1;
        end
        if (release_frame) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    // Bank pointers, fill counter and the read-mux select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full      <= '0;
            wr_bank   <= '0;
            rd_bank   <= '0;
            rd_bank_q <= '0;
            wr_count  <= '0;
        end else begin
            full      <= full_next;
            rd_bank_q <= rd_bank;
            if (xfer) begin
                wr_count <= fill_done ? '0 : wr_count + ADDR_W'(1);
            end
            if (fill_done) begin
                wr_bank <= ~wr_bank;
            end
            if (release_frame) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

`ifdef CLASSIFIER_FEEDER_FRAME_COUNT_EN
    // Free-running count of accepted releases; wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_released <= '0;
        end else if (release_frame) begin
            frames_released <= frames_released + 16'd1;
        end
    end
`endif

    // Both banks read every cycle; the registered rd_bank picks the matching result.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        feeder_frame_bank u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (xfer && (wr_bank == bank_sel_t'(b))),
            .waddr (wr_count),
            .wdata (pixel_in_data),
            .raddr (classifier_input_address_a),
            .rdata (bank_rdata[b])
        );
    end

    assign classifier_input_read_data_a     = DATA_W'(bank_rdata[rd_bank_q]);
    assign classifier_input_valid_read_data = {7'b0, frame_ready};

endmodule

// File: tb/tb_classifier_frame_feeder.sv
// tb_classifier_frame_feeder: directed and random stimulus against a frame-queue model
// of classifier_frame_feeder (completed frames kept as a FIFO of pixels).
module tb_classifier_frame_feeder;
    import classifier_feeder_pkg::*;

    localparam int PIX = 784;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pixel_in_data;
    logic        pixel_in_valid;
    logic        pixel_in_ready;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  valid_rd;
    logic [9:0]  addr;
    logic [15:0] rd_data;
`ifdef CLASSIFIER_FEEDER_FRAME_COUNT_EN
    logic [15:0] frames_released;
`endif

    always #5 clk = ~clk;

    classifier_frame_feeder dut (
        .clk                               (clk),
        .reset                             (reset),
        .pixel_in_data                     (pixel_in_data),
        .pixel_in_valid                    (pixel_in_valid),
        .pixel_in_ready                    (pixel_in_ready),
        .classifier_input_valid_write_en   (we),
        .classifier_input_valid_write_data (wdata),
        .classifier_input_valid_read_data  (valid_rd),
        .classifier_input_address_a        (addr),
        .classifier_input_read_data_a      (rd_data)
`ifdef CLASSIFIER_FEEDER_FRAME_COUNT_EN
        ,
        .frames_released                   (frames_released)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: completed frames back to back (oldest first), plus the frame being filled.
    logic [7:0] done_q [$];
    logic [7:0] part_q [$];
    int         rel_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        pixel_in_valid = 1'b0;
        pixel_in_data  = 8'h00;
        we             = 1'b0;
        wdata          = 8'h00;
        addr           = 10'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, 32'(pixel_in_ready), 32'd0);
        check_eq({tag, "_valid"}, 32'(valid_rd), 32'd0);
        check_eq({tag, "_rdata"}, 32'(rd_data), 32'd0);
`ifdef CLASSIFIER_FEEDER_FRAME_COUNT_EN
        check_eq({tag, "_released"}, 32'(frames_released), 32'd0);
`endif
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        check_reset_values("rst_now");
        repeat (cycles) @(posedge clk);
        #1;
        check_reset_values("rst_hold");
        done_q.delete();
        part_q.delete();
        rel_count = 0;
        reset = 1'b0;
        #1;
        check_eq("rst_release_ready", 32'(pixel_in_ready), 32'd1);
    endtask

    // One clock: predict from pre-edge state, advance the model, compare after the edge.
    task automatic step();
        int          n;
        bit          xfer;
        bit          rel;
        bit          rd_known;
        logic [15:0] rd_exp;
        n        = done_q.size() / PIX;
        xfer     = pixel_in_valid && (n < 2);
        rel      = we && !wdata[0] && (n >= 1);
        rd_known = 1'b0;
        rd_exp   = 16'h0;
        if (int'(addr) >= PIX) begin
            rd_known = 1'b1;
        end else if (n >= 1) begin
            rd_known = 1'b1;
            rd_exp   = {8'h00, done_q[addr]};
        end
        @(posedge clk);
        #1;
        if (rel) begin
            repeat (PIX) void'(done_q.pop_front());
            rel_count++;
        end
        if (xfer) begin
            part_q.push_back(pixel_in_data);
            if (part_q.size() == PIX) begin
                done_q = {done_q, part_q};
                part_q.delete();
            end
        end
        n = done_q.size() / PIX;
        check_eq("ready", 32'(pixel_in_ready), 32'(n < 2));
        check_eq("valid_read_data", 32'(valid_rd), 32'(n >= 1));
        if (rd_known) begin
            check_eq("read_data_a", 32'(rd_data), 32'(rd_exp));
        end
`ifdef CLASSIFIER_FEEDER_FRAME_COUNT_EN
        check_eq("frames_released", 32'(frames_released), 32'(rel_count[15:0]));
`endif
    endtask

    task automatic stream(input int count, input bit use_const, input logic [7:0] value);
        for (int i = 0; i < count; i++) begin
            pixel_in_valid = 1'b1;
            pixel_in_data  = use_const ? value : 8'($urandom);
            addr           = 10'($urandom_range(0, 1023));
            step();
        end
        pixel_in_valid = 1'b0;
    endtask

    initial begin
        drive_idle();
        do_reset(3);

        // Raster-indexed frame, then reads in and out of range.
        for (int i = 0; i < PIX; i++) begin
            pixel_in_valid = 1'b1;
            pixel_in_data  = 8'(i);
            addr           = 10'd5;
            step();
        end
        pixel_in_valid = 1'b0;
        check_eq("frame1_valid", 32'(valid_rd), 32'h01);
        addr = 10'd5;
        step();
        check_eq("addr5", 32'(rd_data), 32'h0005);
        addr = 10'd900;
        step();
        check_eq("addr900", 32'(rd_data), 32'h0000);

        // Three frames, no release: stall after two, release reopens the freed bank.
        do_reset(2);
        stream(PIX, 1'b1, 8'h11);
        stream(PIX, 1'b1, 8'h22);
        stream(10, 1'b1, 8'h33);
        check_eq("stalled_ready", 32'(pixel_in_ready), 32'd0);
        we = 1'b1; wdata = 8'h00; pixel_in_valid = 1'b1; pixel_in_data = 8'h33;
        step();
        we = 1'b0;
        check_eq("release_ready", 32'(pixel_in_ready), 32'd1);
        stream(PIX, 1'b1, 8'h33);
        addr = 10'd17;
        step();
        check_eq("frame22_read", 32'(rd_data), 32'h0022);

        // Ignored writes: bit0 set, and release with nothing ready.
        do_reset(2);
        we = 1'b1; wdata = 8'h01;
        step();
        wdata = 8'h00;
        step();
        we = 1'b0;
        check_eq("ignored_valid", 32'(valid_rd), 32'h00);
        check_eq("ignored_ready", 32'(pixel_in_ready), 32'd1);

        // Last pixel of frame 1 and release of frame 0 on the same edge.
        do_reset(2);
        stream(PIX, 1'b0, 8'h00);
        stream(PIX - 1, 1'b0, 8'h00);
        pixel_in_valid = 1'b1; pixel_in_data = 8'h5A;
        we = 1'b1; wdata = 8'h00;
        step();
        we = 1'b0; pixel_in_valid = 1'b0;
        check_eq("simul_valid", 32'(valid_rd), 32'h01);
        check_eq("simul_ready", 32'(pixel_in_ready), 32'd1);
        addr = 10'(PIX - 1);
        step();
        check_eq("simul_last_pixel", 32'(rd_data), 32'h005A);

        // Reset mid-frame, then a fresh frame reads back.
        do_reset(2);
        for (int i = 0; i < 400; i++) begin
            pixel_in_valid = ($urandom_range(0, 3) != 0);
            pixel_in_data  = 8'($urandom);
            step();
        end
        do_reset(2);
        stream(PIX, 1'b0, 8'h00);
        for (int i = 0; i < 24; i++) begin
            addr = 10'($urandom_range(0, PIX - 1));
            step();
        end

        // Random traffic with occasional releases and decoy writes.
        for (int i = 0; i < 4000; i++) begin
            pixel_in_valid = ($urandom_range(0, 3) != 0);
            pixel_in_data  = 8'($urandom);
            we             = ($urandom_range(0, 255) < 2);
            wdata          = 8'($urandom);
            addr           = 10'($urandom_range(0, 1023));
            step();
        end
        drive_idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
